lpc_io_target: RTL



---
 rtl/lpc_io_target.sv | 118 +++++++++++
 1 files changed

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes host frames into single-cycle register strobes and returns read data on LAD.
// Optional LPC_SYNC_WAIT_EN inserts one short-wait SYNC cycle ahead of read SYNC.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h0700
) (
    input  logic       LpcClock,
    input  logic       rst_n,
    input  logic       LFRAME_n,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    output logic [7:0] Addr,
    output logic       Rd,
    output logic       Wr,
    output logic [7:0] DataWr,
    input  logic [7:0] DataRd
);

    typedef enum logic [3:0] {
        IDLE, CYCTYPE, ADDR, WDATA0, WDATA1, HTAR0, HTAR1, SWAIT,
        SYNC, RDATA0, RDATA1, PTAR0, PTAR1, IGNORE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  nib_cnt;
    logic [11:0] addr_sr;
    logic        is_wr;
    logic [7:0]  rd_buf;
    logic        addr_hit;

    // First three address nibbles are held in addr_sr; the fourth is still on LAD_in.
    assign addr_hit = (addr_sr[11:4] == BASE_ADDR[15:8]);

    always_ff @(posedge LpcClock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!LFRAME_n) begin
            state_nxt = (LAD_in == 4'h0) ? CYCTYPE : IGNORE;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                CYCTYPE: state_nxt = (LAD_in[3:2] == 2'b00) ? ADDR : IGNORE;
                ADDR: begin
                    if (nib_cnt == 2'd0) begin
                        if (!addr_hit)  state_nxt = IGNORE;
                        else if (is_wr) state_nxt = WDATA0;
                        else            state_nxt = HTAR0;
                    end
                end
                WDATA0:  state_nxt = WDATA1;
                WDATA1:  state_nxt = HTAR0;
                HTAR0:   state_nxt = HTAR1;
`ifdef LPC_SYNC_WAIT_EN
                HTAR1:   state_nxt = is_wr ? SYNC : SWAIT;
`else
                HTAR1:   state_nxt = SYNC;
`endif
                SWAIT:   state_nxt = SYNC;
                SYNC:    state_nxt = is_wr ? PTAR0 : RDATA0;
                RDATA0:  state_nxt = RDATA1;
                RDATA1:  state_nxt = PTAR0;
                PTAR0:   state_nxt = PTAR1;
                PTAR1:   state_nxt = IDLE;
                IGNORE:  state_nxt = IGNORE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        LAD_oe  = 1'b0;
        LAD_out = 4'hF;
        Rd      = 1'b0;
        Wr      = 1'b0;
        case (state)
            HTAR0:  Rd = !is_wr;
            SWAIT:  begin LAD_oe = 1'b1; LAD_out = 4'h5; end
            SYNC:   begin LAD_oe = 1'b1; LAD_out = 4'h0; Wr = is_wr; end
            RDATA0: begin LAD_oe = 1'b1; LAD_out = rd_buf[3:0]; end
            RDATA1: begin LAD_oe = 1'b1; LAD_out = rd_buf[7:4]; end
            PTAR0:  LAD_oe = 1'b1;
            default: ;
        endcase
    end

    // Datapath loads are suppressed on an abort edge so a discarded cycle leaves no trace.
    always_ff @(posedge LpcClock or negedge rst_n) begin
        if (!rst_n) begin
            nib_cnt <= '0;
            addr_sr <= '0;
            is_wr   <= 1'b0;
            rd_buf  <= '0;
            Addr    <= '0;
            DataWr  <= '0;
        end else if (LFRAME_n) begin
            case (state)
                CYCTYPE: begin
                    is_wr   <= LAD_in[1];
                    nib_cnt <= 2'd3;
                end
                ADDR: begin
                    addr_sr <= {addr_sr[7:0], LAD_in};
                    nib_cnt <= nib_cnt - 2'd1;
                    if (nib_cnt == 2'd0 && addr_hit) Addr <= {addr_sr[3:0], LAD_in};
                end
                WDATA0: DataWr[3:0] <= LAD_in;
                WDATA1: DataWr[7:4] <= LAD_in;
                SYNC:   if (!is_wr) rd_buf <= DataRd;
                default: ;
            endcase
        end
    end

endmodule
